// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared game-wide constants: screen geometry, colour width, the blitter state
// encoding and a small on-screen test helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package game_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOUR_W = 3;

  // Blitter state encoding, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Full-width sums are compared so that wrapped coordinates never look valid.
  function automatic logic in_screen(input logic [9:0] sx, input logic [8:0] sy);
    return (sx < 10'(SCREEN_W)) && (sy < 9'(SCREEN_H));
  endfunction

endpackage

// File: rtl/raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Walks (cx, cy) over a rectangle in raster order, cx fastest, from (0,0) to
// (w_last, h_last). Holds at the final position once reached.
// Ports:
//   clock, resetn  : clock, asynchronous active-low reset
//   start          : restart the walk at (0,0) on the next edge
//   step           : advance one position on the next edge
//   w_last, h_last : last column / last row index
//   cx, cy         : current position
//   last           : current position is (w_last, h_last)
// -----------------------------------------------------------------------------
module raster_counter (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       step,
  input  logic [5:0] w_last,
  input  logic [5:0] h_last,
  output logic [5:0] cx,
  output logic [5:0] cy,
  output logic       last
);

  logic [5:0] cx_q, cx_d;
  logic [5:0] cy_q, cy_d;

  assign last = (cx_q == w_last) && (cy_q == h_last);
  assign cx   = cx_q;
  assign cy   = cy_q;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (start) begin
      cx_d = '0;
      cy_d = '0;
    end else if (step && !last) begin
      if (cx_q == w_last) begin
        cx_d = '0;
        cy_d = cy_q + 6'd1;
      end else begin
        cx_d = cx_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// -----------------------------------------------------------------------------
// sprite_blitter
// Copies a sprite rectangle from a 1-cycle-latency ROM to a VGA write port, or
// fills the rectangle with COLOUR_BG (erase). Pixels off the 320x240 screen are
// clipped (plot=0) without changing timing.
// Optional feature: define SPRITE_BLITTER_TRANSPARENT_EN to suppress plotting
// of non-erase pixels whose ROM colour equals TRANSPARENT_KEY.
// Handshake: req is sampled only in IDLE; the accepting edge latches x0, y0,
// w_last, h_last and erase. busy is high from then until the done pulse
// (inclusive); req is ignored while busy. done is high for exactly one cycle.
// Ports:
//   clock, resetn            : clock, asynchronous active-low reset
//   req, erase               : draw request, erase select
//   x0, y0, w_last, h_last   : rectangle origin and last col/row index
//   rom_x, rom_y, rom_colour : sprite ROM address out, data in (1-cycle later)
//   x, y, colour, plot       : VGA adapter write port
//   busy, done               : status
//   state_dbg                : current FSM state (debug)
// -----------------------------------------------------------------------------
module sprite_blitter
  import game_pkg::*;
#(
  parameter logic [COLOUR_W-1:0] COLOUR_BG       = 3'b000,
  parameter logic [COLOUR_W-1:0] TRANSPARENT_KEY = 3'b111
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                req,
  input  logic                erase,
  input  logic [8:0]          x0,
  input  logic [7:0]          y0,
  input  logic [5:0]          w_last,
  input  logic [5:0]          h_last,
  output logic [5:0]          rom_x,
  output logic [5:0]          rom_y,
  input  logic [COLOUR_W-1:0] rom_colour,
  output logic [8:0]          x,
  output logic [7:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
);

  logic [1:0] state_q, state_d;
  logic       accept;
  logic       last;

  // Latched request
  logic [8:0] x0_q;
  logic [7:0] y0_q;
  logic [5:0] w_q, h_q;
  logic       erase_q;

  // Stage 1: screen coordinates of the address issued last cycle
  logic       v1_q;
  logic [9:0] sx1_q;
  logic [8:0] sy1_q;
  logic       on1_q;

  // Stage 2: registered write port
  logic                plot_q;
  logic [8:0]          x_q;
  logic [7:0]          y_q;
  logic [COLOUR_W-1:0] colour_q;

  logic key_hit;
  logic draw;

  assign accept    = (state_q == ST_IDLE) && req;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign state_dbg = state_q;

  raster_counter u_raster (
    .clock  (clock),
    .resetn (resetn),
    .start  (accept),
    .step   (state_q == ST_SCAN),
    .w_last (w_q),
    .h_last (h_q),
    .cx     (rom_x),
    .cy     (rom_y),
    .last   (last)
  );

  // FLUSH waits until stage 1 has drained, so DONE starts with plot back at 0.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (req)   state_d = ST_SCAN;
      ST_SCAN:  if (last)  state_d = ST_FLUSH;
      ST_FLUSH: if (!v1_q) state_d = ST_DONE;
      default:             state_d = ST_IDLE;
    endcase
  end

`ifdef SPRITE_BLITTER_TRANSPARENT_EN
  assign key_hit = !erase_q && (rom_colour == TRANSPARENT_KEY);
`else
  // Comparison kept only so the key parameter stays referenced; always false.
  assign key_hit = (rom_colour == TRANSPARENT_KEY) & 1'b0;
`endif

  assign draw = v1_q && on1_q && !key_hit;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      erase_q  <= 1'b0;
      v1_q     <= 1'b0;
      sx1_q    <= '0;
      sy1_q    <= '0;
      on1_q    <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        x0_q    <= x0;
        y0_q    <= y0;
        w_q     <= w_last;
        h_q     <= h_last;
        erase_q <= erase;
      end
      v1_q   <= (state_q == ST_SCAN);
      sx1_q  <= {1'b0, x0_q} + {4'b0, rom_x};
      sy1_q  <= {1'b0, y0_q} + {3'b0, rom_y};
      on1_q  <= in_screen({1'b0, x0_q} + {4'b0, rom_x}, {1'b0, y0_q} + {3'b0, rom_y});
      plot_q <= draw;
      // Write port holds its last values whenever nothing is plotted.
      if (draw) begin
        x_q      <= sx1_q[8:0];
        y_q      <= sy1_q[7:0];
        colour_q <= erase_q ? COLOUR_BG : rom_colour;
      end
    end
  end

  assign plot   = plot_q;
  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// -----------------------------------------------------------------------------
// tb_sprite_blitter
// Directed bench for sprite_blitter with a behavioural 1-cycle-latency ROM.
// -----------------------------------------------------------------------------
module tb_sprite_blitter;

  // Clock / reset
  logic clock  = 1'b0;
  logic resetn = 1'b0;
  always #5 clock = ~clock;

  // DUT signals
  logic       req = 1'b0;
  logic       erase = 1'b0;
  logic [8:0] x0 = '0;
  logic [7:0] y0 = '0;
  logic [5:0] w_last = '0;
  logic [5:0] h_last = '0;
  logic [2:0] rom_colour = '0;
  logic [5:0] rom_x, rom_y;
  logic [8:0] x;
  logic [7:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int rom_mode = 0;

  sprite_blitter dut (
    .clock      (clock),
    .resetn     (resetn),
    .req        (req),
    .erase      (erase),
    .x0         (x0),
    .y0         (y0),
    .w_last     (w_last),
    .h_last     (h_last),
    .rom_x      (rom_x),
    .rom_y      (rom_y),
    .rom_colour (rom_colour),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot),
    .busy       (busy),
    .done       (done),
    .state_dbg  (state_dbg)
  );

  // Sprite contents: mode 0 never produces 3'b111, mode 2 has 3'b111 on odd columns.
  function automatic logic [2:0] rom_fn(input int mode, input int px, input int py);
    if (mode == 2) return (px % 2 == 1) ? 3'b111 : 3'(py % 4);
    return 3'((px + 2 * py) % 7);
  endfunction

  // ROM model: registered read, mode 1 returns random data.
  always @(posedge clock) begin
    if (rom_mode == 1) rom_colour <= 3'($urandom_range(0, 7));
    else               rom_colour <= rom_fn(rom_mode, int'(rom_x), int'(rom_y));
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start a blit from a negedge and follow it until its done cycle.
  // exp_wait: negedges until busy is seen (1 from IDLE, 2 when issued in DONE).
  task automatic run_blit(input int bx, input int by, input int bw, input int bh,
                          input logic be, input int exp_wait, input int exp_plots,
                          input logic keep, input logic [8:0] next_x);
    int waited, n, p, px, py, npl, ex, ey;
    logic exp_plot;
    logic [2:0] ec;
    x0 = 9'(bx); y0 = 8'(by); w_last = 6'(bw); h_last = 6'(bh); erase = be; req = 1'b1;
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (!busy && waited < 10);
    chk("accept_wait", waited, exp_wait);
    if (keep) x0 = next_x;
    else begin
      // Scrambled inputs after acceptance must have no effect.
      req = 1'b0;
      x0 = 9'($urandom); y0 = 8'($urandom);
      w_last = 6'($urandom); h_last = 6'($urandom); erase = ~be;
    end
    n = (bw + 1) * (bh + 1);
    npl = 0;
    for (int j = 1; j <= n + 2; j++) begin
      @(negedge clock);
      if (!keep && n > 4 && j == 3) req = 1'b1;
      if (!keep && n > 4 && j == 4) req = 1'b0;
      exp_plot = 1'b0;
      ex = 0; ey = 0; ec = '0;
      if (j >= 2 && j <= n + 1) begin
        p  = j - 2;
        px = p % (bw + 1);
        py = p / (bw + 1);
        ex = bx + px;
        ey = by + py;
        ec = be ? 3'b000 : rom_fn(rom_mode, px, py);
        exp_plot = (ex < 320) && (ey < 240);
`ifdef SPRITE_BLITTER_TRANSPARENT_EN
        if (!be && ec == 3'b111) exp_plot = 1'b0;
`endif
      end
      chk("plot", plot, exp_plot);
      chk("busy", busy, 1);
      chk("done", done, (j == n + 2));
      if (plot) begin
        npl++;
        if (exp_plot) begin
          chk("x", x, ex);
          chk("y", y, ey);
          chk("colour", colour, ec);
        end
      end
    end
    chk("plot_count", npl, exp_plots);
  endtask

  initial begin : main
    int seen;
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_plot", plot, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_rom_x", rom_x, 0);
    chk("rst_rom_y", rom_y, 0);
    chk("rst_state", state_dbg, 0);
    resetn = 1'b1;
    @(negedge clock);

    // Full in-screen sprite copy
    rom_mode = 0;
    run_blit(100, 190, 26, 47, 1'b0, 1, 1296, 1'b0, 9'd0);
    @(negedge clock);

    // Erase over random ROM data
    rom_mode = 1;
    run_blit(100, 190, 26, 47, 1'b1, 1, 1296, 1'b0, 9'd0);
    @(negedge clock);

    // Clipped at bottom-right corner: 5x5 visible
    rom_mode = 0;
    run_blit(315, 235, 9, 16, 1'b0, 1, 25, 1'b0, 9'd0);
    @(negedge clock);

    // Transparency on odd columns
    rom_mode = 2;
`ifdef SPRITE_BLITTER_TRANSPARENT_EN
    run_blit(8, 8, 7, 3, 1'b0, 1, 16, 1'b0, 9'd0);
`else
    run_blit(8, 8, 7, 3, 1'b0, 1, 32, 1'b0, 9'd0);
`endif
    @(negedge clock);

    // Reset in the middle of a blit
    rom_mode = 0;
    x0 = 9'd10; y0 = 8'd10; w_last = 6'd15; h_last = 6'd15; erase = 1'b0; req = 1'b1;
    @(negedge clock);
    chk("mid_accept", busy, 1);
    req = 1'b0;
    seen = 0;
    for (int i = 0; i < 200 && seen < 50; i++) begin
      @(negedge clock);
      if (plot) seen++;
    end
    chk("mid_plots_seen", seen, 50);
    resetn = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_plot", plot, 0);
    chk("abort_x", x, 0);
    chk("abort_y", y, 0);
    chk("abort_colour", colour, 0);
    chk("abort_rom_x", rom_x, 0);
    chk("abort_rom_y", rom_y, 0);
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("post_abort_done", done, 0);
      chk("post_abort_busy", busy, 0);
    end
    run_blit(0, 0, 0, 0, 1'b0, 1, 1, 1'b0, 9'd0);
    @(negedge clock);

    // Back-to-back with req held high across DONE
    run_blit(20, 30, 1, 1, 1'b0, 1, 4, 1'b1, 9'd40);
    run_blit(40, 30, 1, 1, 1'b0, 2, 4, 1'b0, 9'd0);
    @(negedge clock);
    chk("final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
